// File: rtl/i2s_tx_multi.sv
// -----------------------------------------------------------------------------
// i2s_tx_multi
//   Multi-lane I2S / left-justified / right-justified serialiser. LANES stereo
//   lanes share one SCLK/LRCLK pair. Each channel is a DATA_W-bit two's
//   complement sample carried in a SLOT_W-bit slot. Samples arrive through a
//   valid/ready port backed by a one-deep holding buffer. When a frame starts
//   and the buffer is empty, the previous samples are replayed and an underrun
//   is flagged.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   fmt          00 I2S, 01 left-justified, 10 right-justified, 11 as I2S;
//                latched at frame start
//   s_data       packed samples; lane n = s_data[(2n+2)*DATA_W-1 : 2n*DATA_W]
//                laid out as {left, right}
//   s_valid      s_data valid
//   s_ready      holding buffer empty
//   sdout        serial data, one bit per lane
//   sclk         bit clock (the DAC samples on its rising edge)
//   lrclk        word select
//   load         one-cycle pulse at each frame start
//   underrun     one-cycle pulse when a frame starts with an empty buffer
//   underrun_cnt saturating underrun count; present only when
//                I2S_TX_MULTI_UNDERRUN_CNT_EN is defined
//
// Build option
//   I2S_TX_MULTI_UNDERRUN_CNT_EN adds the underrun_cnt port and its counter.
// -----------------------------------------------------------------------------
module i2s_tx_multi #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int LANES    = 1,
  parameter int SCLK_DIV = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  fmt,
  input  logic [LANES*2*DATA_W-1:0]   s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [LANES-1:0]            sdout,
  output logic                        sclk,
  output logic                        lrclk,
  output logic                        load,
  output logic                        underrun
`ifdef I2S_TX_MULTI_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int SAMP_W  = LANES * 2 * DATA_W;
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BCNT_W  = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(SCLK_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(FRAME_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(SLOT_W);

  // Places one sample in its slot. Slot bit SLOT_W-1 is sent first (k = 0).
  function automatic logic [SLOT_W-1:0] fmt_slot(input logic [DATA_W-1:0] s,
                                                 input logic [1:0]        f);
    logic [SLOT_W-1:0] lj;
    lj = SLOT_W'(s) << (SLOT_W - DATA_W);
    case (f)
      2'b01:   fmt_slot = lj;
      2'b10:   fmt_slot = SLOT_W'($signed(s));
      default: fmt_slot = lj >> 1;  // I2S: one-bit delay after the LRCLK edge
    endcase
  endfunction

  logic [DIV_W-1:0]                div_q, div_d;
  logic                            sclk_q, sclk_d;
  logic [BCNT_W-1:0]               bcnt_q, bcnt_d;
  logic                            start_q;
  logic [1:0]                      fmt_q, fmt_d;
  logic                            buf_full_q, buf_full_d;
  logic [SAMP_W-1:0]               buf_q, buf_d;
  logic [SAMP_W-1:0]               last_q, last_d;
  logic [LANES-1:0][FRAME_W-1:0]   sh_q, sh_d;
  logic [LANES-1:0]                sdout_q, sdout_d;
  logic                            lrclk_q, lrclk_d;

  logic                            tick;
  logic                            frame_start;
  logic [1:0]                      fmt_in;
  logic [1:0]                      fmt_eff;
  logic                            justified;
  logic                            xfer;
  logic [SAMP_W-1:0]               src;
  logic [DATA_W-1:0]               lane_l, lane_r;
  logic [FRAME_W-1:0]              lane_word;

  always_comb begin
    // A tick is the falling SCLK edge. start_q stands in for a tick in the
    // first cycle after reset, which keeps every frame exactly one frame period.
    tick        = sclk_q && (div_q == DIV_MAX);
    frame_start = start_q || (tick && (bcnt_q == BCNT_MAX));
    fmt_in      = (fmt == 2'b11) ? 2'b00 : fmt;
    fmt_eff     = frame_start ? fmt_in : fmt_q;
    justified   = (fmt_eff != 2'b00);
    xfer        = s_valid && !buf_full_q;
    src         = buf_full_q ? buf_q : last_q;

    div_d  = div_q;
    sclk_d = sclk_q;
    if (!start_q) begin
      if (div_q == DIV_MAX) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    bcnt_d = bcnt_q;
    if (frame_start) begin
      bcnt_d = '0;
    end else if (tick) begin
      bcnt_d = bcnt_q + 1'b1;
    end

    fmt_d = fmt_eff;

    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    last_d     = last_q;
    if (frame_start) begin
      last_d     = src;
      buf_full_d = 1'b0;
    end
    // A word accepted on a frame start lands in the buffer for the next frame.
    if (xfer) begin
      buf_full_d = 1'b1;
      buf_d      = s_data;
    end

    sh_d      = sh_q;
    sdout_d   = sdout_q;
    lrclk_d   = lrclk_q;
    lane_l    = '0;
    lane_r    = '0;
    lane_word = '0;
    if (frame_start) begin
      lrclk_d = justified;  // left half: low for I2S, high otherwise
      for (int n = 0; n < LANES; n++) begin
        lane_l     = src[(2*n+2)*DATA_W-1 -: DATA_W];
        lane_r     = src[(2*n+1)*DATA_W-1 -: DATA_W];
        lane_word  = {fmt_slot(lane_l, fmt_eff), fmt_slot(lane_r, fmt_eff)};
        sdout_d[n] = lane_word[FRAME_W-1];
        sh_d[n]    = lane_word << 1;
      end
    end else if (tick) begin
      lrclk_d = (bcnt_d >= BCNT_HALF) ^ justified;
      for (int n = 0; n < LANES; n++) begin
        sdout_d[n] = sh_q[n][FRAME_W-1];
        sh_d[n]    = sh_q[n] << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      bcnt_q     <= '0;
      start_q    <= 1'b1;
      fmt_q      <= 2'b00;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      last_q     <= '0;
      sh_q       <= '0;
      sdout_q    <= '0;
      lrclk_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      bcnt_q     <= bcnt_d;
      start_q    <= 1'b0;
      fmt_q      <= fmt_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      sh_q       <= sh_d;
      sdout_q    <= sdout_d;
      lrclk_q    <= lrclk_d;
    end
  end

  // sclk_q falls on the same clk edge that registers the new data bit, so
  // sclk, sdout and lrclk stay mutually aligned.
  assign sclk    = sclk_q;
  assign sdout   = sdout_q;
  assign lrclk   = lrclk_q;
  assign s_ready = ~buf_full_q;
  assign load    = frame_start && !reset;
  // The frame that follows reset never reports an underrun.
  assign underrun = frame_start && !buf_full_q && !start_q && !reset;

`ifdef I2S_TX_MULTI_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule
